// File: rtl/dmi_debug_target.sv
// Minimal RISC-V debug-module DMI slave: data0/1, dmcontrol, dmstatus, abstractcs, command,
// with a single-outstanding request/response FSM and a timed abstract-command engine.
module dmi_debug_target #(
   parameter int RESP_LATENCY = 1,
   parameter int CMD_CYCLES   = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        debug_req_valid,
   output logic        debug_req_ready,
   input  logic [6:0]  debug_req_bits_addr,
   input  logic [1:0]  debug_req_bits_op,
   input  logic [31:0] debug_req_bits_data,
   output logic        debug_resp_valid,
   input  logic        debug_resp_ready,
   output logic [1:0]  debug_resp_bits_resp,
   output logic [31:0] debug_resp_bits_data,
   output logic        halted
);

   localparam logic [6:0] A_DATA0 = 7'h04;
   localparam logic [6:0] A_DATA1 = 7'h05;
   localparam logic [6:0] A_DMCTL = 7'h10;
   localparam logic [6:0] A_DMSTS = 7'h11;
   localparam logic [6:0] A_ACS   = 7'h16;
   localparam logic [6:0] A_CMD   = 7'h17;
   localparam logic [3:0] LAT_INIT = 4'(RESP_LATENCY - 1);
   localparam logic [7:0] CMD_INIT = 8'(CMD_CYCLES);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t      state, state_nxt;
   logic [3:0]  lat_cnt;
   logic [31:0] data0, data1;
   logic        dmactive, haltreq, busy;
   logic [2:0]  cmderr;
   logic [7:0]  cmd_cnt;
   logic [15:0] cmd_regno;
   logic        cmd_load;
   logic        accept, is_rd, is_wr, data_access;
   logic [31:0] rd_mux;

   assign accept      = debug_req_valid && debug_req_ready;
   assign is_rd       = (debug_req_bits_op == 2'd1);
   assign is_wr       = (debug_req_bits_op == 2'd2);
   assign data_access = (is_rd || is_wr) &&
                        (debug_req_bits_addr == A_DATA0 || debug_req_bits_addr == A_DATA1);

   always_comb begin
      state_nxt        = state;
      debug_req_ready  = 1'b0;
      debug_resp_valid = 1'b0;
      case (state)
         S_IDLE: begin
            debug_req_ready = 1'b1;
            if (debug_req_valid)
               state_nxt = (RESP_LATENCY == 1) ? S_RESP : S_WAIT;
         end
         S_WAIT: if (lat_cnt <= 4'd1) state_nxt = S_RESP;
         S_RESP: begin
            debug_resp_valid = 1'b1;
            if (debug_resp_ready) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      rd_mux = 32'h0;
      case (debug_req_bits_addr)
         A_DATA0: rd_mux = data0;
         A_DATA1: rd_mux = data1;
         A_DMCTL: rd_mux = {haltreq, 30'h0, dmactive};
         A_DMSTS: rd_mux = {20'h0, ~halted, ~halted, halted, halted, 1'b1, 3'b000, 4'd2};
         A_ACS:   rd_mux = {19'h0, busy, 1'b0, cmderr, 4'h0, 4'd2};
         default: rd_mux = 32'h0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state                <= S_IDLE;
         lat_cnt              <= 4'h0;
         debug_resp_bits_resp <= 2'd0;
         debug_resp_bits_data <= 32'h0;
         data0                <= 32'h0;
         data1                <= 32'h0;
         dmactive             <= 1'b0;
         haltreq              <= 1'b0;
         halted               <= 1'b0;
         busy                 <= 1'b0;
         cmderr               <= 3'd0;
         cmd_cnt              <= 8'h0;
         cmd_regno            <= 16'h0;
         cmd_load             <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept)
            lat_cnt <= LAT_INIT;
         else if (state == S_WAIT && lat_cnt != 4'd0)
            lat_cnt <= lat_cnt - 4'd1;

         if (dmactive && haltreq) halted <= 1'b1;

         // Completion runs regardless of the transaction FSM; later accept effects override it
         if (busy) begin
            if (cmd_cnt <= 8'd1) begin
               busy <= 1'b0;
               if (cmd_load) data0 <= {16'h0, cmd_regno};
            end else begin
               cmd_cnt <= cmd_cnt - 8'd1;
            end
         end

         if (accept) begin
            debug_resp_bits_resp <= (debug_req_bits_op == 2'd3) ? 2'd2 : 2'd0;
            debug_resp_bits_data <= is_rd ? rd_mux : 32'h0;

            if (data_access && busy) begin
               if (cmderr == 3'd0) cmderr <= 3'd1;
            end else if (is_wr) begin
               case (debug_req_bits_addr)
                  A_DATA0: data0 <= debug_req_bits_data;
                  A_DATA1: data1 <= debug_req_bits_data;
                  A_DMCTL: begin
                     dmactive <= debug_req_bits_data[0];
                     if (!debug_req_bits_data[0]) begin
                        data0   <= 32'h0;
                        data1   <= 32'h0;
                        haltreq <= 1'b0;
                        cmderr  <= 3'd0;
                        busy    <= 1'b0;
                        halted  <= 1'b0;
                     end else begin
                        haltreq <= debug_req_bits_data[31];
                        if (debug_req_bits_data[31])      halted <= 1'b1;
                        else if (debug_req_bits_data[30]) halted <= 1'b0;
                     end
                  end
                  A_ACS: cmderr <= cmderr & ~debug_req_bits_data[10:8];
                  A_CMD: begin
                     if (cmderr != 3'd0) begin
                        cmderr <= cmderr;
                     end else if (busy) begin
                        cmderr <= 3'd1;
                     end else if (debug_req_bits_data[31:24] != 8'h0) begin
                        cmderr <= 3'd2;
                     end else if (!halted) begin
                        cmderr <= 3'd4;
                     end else begin
                        busy      <= 1'b1;
                        cmd_cnt   <= CMD_INIT;
                        cmd_regno <= debug_req_bits_data[15:0];
                        cmd_load  <= debug_req_bits_data[17] && !debug_req_bits_data[16];
                     end
                  end
                  default: ;
               endcase
            end
         end
      end
   end

endmodule
